// File: rtl/operand_issue_ctl.sv
// Operand-fetch issue controller: a busy-bit scoreboard holds back RAW/WAW hazards,
// then reads the register file, size-masks the operands and fills an execute-facing slot.
module operand_issue_ctl #(
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [7:0]  dec_op,
  input  logic [1:0]  dec_srcty,
  input  logic [3:0]  dec_srcreg,
  input  logic [63:0] dec_srcval,
  input  logic [3:0]  dec_dstreg,
  input  logic        dec_dst_wr,
  input  logic [1:0]  dec_size,
  output logic [3:0]  rf_rd_addr0,
  output logic [3:0]  rf_rd_addr1,
  input  logic [63:0] rf_rd_data0,
  input  logic [63:0] rf_rd_data1,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [7:0]  ex_op,
  output logic [3:0]  ex_dstreg,
  output logic        ex_dst_wr,
  output logic [1:0]  ex_size,
  output logic [63:0] ex_oper1,
  output logic [63:0] ex_oper2,
  input  logic        wb_valid,
  input  logic [3:0]  wb_reg,
  output logic [2:0]  inflight
);

  localparam logic [1:0] SRC_REGISTER = 2'd0;
  localparam logic [3:0] MAX_CNT = 4'(MAX_INFLIGHT);

  // RUN: slot empty; HOLD: slot occupied and stalled last cycle; FULL_ADV: slot just loaded
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    HOLD     = 2'd1,
    FULL_ADV = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] busy;
  logic [15:0] busy_nxt;
  logic [3:0]  cnt;
  logic        slot_free;
  logic        hazard;
  logic        at_limit;
  logic        issue_wr;
  logic        wb_ok;
  logic [63:0] src_sel;

  function automatic logic [63:0] size_mask(input logic [63:0] d, input logic [1:0] sz);
    logic [63:0] r;
    case (sz)
      2'd0:    r = {56'h0, d[7:0]};
      2'd1:    r = {48'h0, d[15:0]};
      2'd2:    r = {32'h0, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign rf_rd_addr0 = dec_dstreg;
  assign rf_rd_addr1 = dec_srcreg;
  assign ex_valid    = (state != RUN);
  assign inflight    = cnt[2:0];

  // A busy destination blocks both the oper1 read (RAW) and the overwrite (WAW)
  assign slot_free = !ex_valid || ex_ready;
  assign hazard    = busy[dec_dstreg] || ((dec_srcty == SRC_REGISTER) && busy[dec_srcreg]);
  assign at_limit  = dec_dst_wr && (cnt == MAX_CNT);
  assign dec_ready = dec_valid && !flush && slot_free && !hazard && !at_limit;
  assign issue_wr  = dec_ready && dec_dst_wr;
  assign wb_ok     = wb_valid && busy[wb_reg] && (cnt != 4'd0);
  assign src_sel   = (dec_srcty == SRC_REGISTER) ? rf_rd_data1 : dec_srcval;

  // Writeback and issue never target the same register: an issuing dst is never busy
  always_comb begin
    busy_nxt = busy;
    if (wb_ok) busy_nxt[wb_reg] = 1'b0;
    if (issue_wr) busy_nxt[dec_dstreg] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= 16'h0;
      cnt  <= 4'd0;
    end else begin
      busy <= busy_nxt;
      case ({issue_wr, wb_ok})
        2'b10:   cnt <= cnt + 4'd1;
        2'b01:   cnt <= cnt - 4'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Flush outranks issue and retirement; data fields keep their last values when not loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RUN;
      ex_op     <= 8'h0;
      ex_dstreg <= 4'h0;
      ex_dst_wr <= 1'b0;
      ex_size   <= 2'd0;
      ex_oper1  <= 64'h0;
      ex_oper2  <= 64'h0;
    end else if (flush) begin
      state <= RUN;
    end else if (dec_ready) begin
      state     <= FULL_ADV;
      ex_op     <= dec_op;
      ex_dstreg <= dec_dstreg;
      ex_dst_wr <= dec_dst_wr;
      ex_size   <= dec_size;
      ex_oper1  <= size_mask(rf_rd_data0, dec_size);
      ex_oper2  <= size_mask(src_sel, dec_size);
    end else if (ex_valid && ex_ready) begin
      state <= RUN;
    end else if (ex_valid) begin
      state <= HOLD;
    end else begin
      state <= RUN;
    end
  end

`ifndef SYNTHESIS
  a_wb_protocol: assert property (@(posedge clk) disable iff (!reset_n)
    wb_valid |-> (busy[wb_reg] && (cnt != 4'd0)));
  a_inflight_max: assert property (@(posedge clk) disable iff (!reset_n)
    int'(cnt) <= MAX_INFLIGHT);
  a_inflight_pop: assert property (@(posedge clk) disable iff (!reset_n)
    int'(cnt) == $countones(busy));
`endif

endmodule
